dm_cache_controller: RTL and testbench

- Data-memory cache controller directly downstream of the main decoder and ALU in the single-cycle RISC-V core.
- Consumes MemReadCpu and MemWrite from the decoder, plus the ALU-computed word address and store data.
- Serves loads from a direct-mapped, write-through, no-write-allocate cache.
- Freezes the core with a combinational stall while it refills a line or writes a word through to main memory over a ready-handshake bus.

---
 rtl/dm_cache_controller_pkg.sv | 24 ++
 rtl/dm_cache_controller_if.sv | 30 +++
 rtl/dm_cache_controller_line_store.sv | 47 ++++
 rtl/dm_cache_controller.sv | 188 ++++++++++++++++++
 tb/tb_dm_cache_controller.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/dm_cache_controller_pkg.sv
// rtl/dm_cache_controller_pkg.sv - shared widths, state encoding and helpers for the data cache
package dm_cache_controller_pkg;

    localparam int ADDR_W   = 10;
    localparam int INDEX_W  = 5;
    localparam int OFFSET_W = 2;
    localparam int DATA_W   = 32;
    localparam int CNT_W    = 16;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINES    = 2 ** INDEX_W;
    localparam int WORDS    = 2 ** OFFSET_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_WRITE  = 2'd2
    } state_t;

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/dm_cache_controller_if.sv
// rtl/dm_cache_controller_if.sv - core-side and main-memory-side signals of the data cache
interface dm_cache_controller_if;
    import dm_cache_controller_pkg::*;

    logic              MemReadCpu;
    logic              MemWrite;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              stall;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;

    modport slave (
        input  MemReadCpu, MemWrite, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
        output cpu_rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
    );

    modport master (
        output MemReadCpu, MemWrite, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
        input  cpu_rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
    );

endinterface

// File: rtl/dm_cache_controller_line_store.sv
// rtl/dm_cache_controller_line_store.sv - tag, valid and data arrays with combinational read
module cache_line_store
    import dm_cache_controller_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [INDEX_W-1:0]  i_rd_index,
    input  logic [OFFSET_W-1:0] i_rd_offset,
    output logic [TAG_W-1:0]    o_rd_tag,
    output logic                o_rd_valid,
    output logic [DATA_W-1:0]   o_rd_word,
    input  logic                i_word_we,
    input  logic [INDEX_W-1:0]  i_word_index,
    input  logic [OFFSET_W-1:0] i_word_offset,
    input  logic [DATA_W-1:0]   i_word_data,
    input  logic                i_tag_we,
    input  logic [INDEX_W-1:0]  i_tag_index,
    input  logic [TAG_W-1:0]    i_tag
);

    logic [LINES-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tags [LINES];
    logic [DATA_W-1:0] r_data [LINES][WORDS];

    assign o_rd_tag   = r_tags[i_rd_index];
    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_word  = r_data[i_rd_index][i_rd_offset];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_tag_we) begin
            r_valid[i_tag_index] <= 1'b1;
        end
    end

    // Tags and data carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (i_tag_we) begin
            r_tags[i_tag_index] <= i_tag;
        end
        if (i_word_we) begin
            r_data[i_word_index][i_word_offset] <= i_word_data;
        end
    end

endmodule

// File: rtl/dm_cache_controller.sv
// rtl/dm_cache_controller.sv - direct-mapped write-through no-allocate data cache with core stall
module dm_cache_controller
    import dm_cache_controller_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    dm_cache_controller_if.slave bus
);

    state_t              r_state, w_next_state;
    logic [TAG_W-1:0]    r_tag;
    logic [INDEX_W-1:0]  r_index;
    logic [OFFSET_W-1:0] r_beat;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_wr_done;
    logic                r_fill_done;
    logic [CNT_W-1:0]    r_hit_count;
    logic [CNT_W-1:0]    r_miss_count;

    logic [TAG_W-1:0]    w_tag;
    logic [INDEX_W-1:0]  w_index;
    logic [OFFSET_W-1:0] w_offset;
    logic [TAG_W-1:0]    w_line_tag;
    logic                w_line_valid;
    logic [DATA_W-1:0]   w_line_word;
    logic                w_hit;

    logic                w_stall;
    logic [DATA_W-1:0]   w_rdata;
    logic                w_rd_hit;
    logic                w_rd_miss;
    logic                w_wr_start;
    logic                w_fill_beat;
    logic                w_fill_last;
    logic                w_mem_req;
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [DATA_W-1:0]   w_mem_wdata;

    logic                w_word_we;
    logic [INDEX_W-1:0]  w_word_index;
    logic [OFFSET_W-1:0] w_word_offset;
    logic [DATA_W-1:0]   w_word_data;

    assign w_tag    = bus.cpu_addr[ADDR_W-1 -: TAG_W];
    assign w_index  = bus.cpu_addr[OFFSET_W +: INDEX_W];
    assign w_offset = bus.cpu_addr[OFFSET_W-1:0];
    assign w_hit    = w_line_valid && (w_line_tag == w_tag);

    // Refill beats and store hits share the single word-write port.
    assign w_word_we     = w_fill_beat | (w_wr_start & w_hit);
    assign w_word_index  = (r_state == ST_REFILL) ? r_index : w_index;
    assign w_word_offset = (r_state == ST_REFILL) ? r_beat : w_offset;
    assign w_word_data   = (r_state == ST_REFILL) ? bus.mem_rdata : bus.cpu_wdata;

    cache_line_store u_store (
        .clk           (clk),
        .rst           (rst),
        .i_rd_index    (w_index),
        .i_rd_offset   (w_offset),
        .o_rd_tag      (w_line_tag),
        .o_rd_valid    (w_line_valid),
        .o_rd_word     (w_line_word),
        .i_word_we     (w_word_we),
        .i_word_index  (w_word_index),
        .i_word_offset (w_word_offset),
        .i_word_data   (w_word_data),
        .i_tag_we      (w_fill_last),
        .i_tag_index   (r_index),
        .i_tag         (r_tag)
    );

    always_comb begin
        w_next_state = r_state;
        w_stall      = 1'b0;
        w_rdata      = '0;
        w_rd_hit     = 1'b0;
        w_rd_miss    = 1'b0;
        w_wr_start   = 1'b0;
        w_fill_beat  = 1'b0;
        w_fill_last  = 1'b0;
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_addr   = '0;
        w_mem_wdata  = '0;
        if (!rst) begin
            case (r_state)
                ST_IDLE: begin
                    // wr_done marks the cycle in which the core retires a finished store.
                    if (!r_wr_done) begin
                        if (bus.MemWrite) begin
                            w_stall      = 1'b1;
                            w_wr_start   = 1'b1;
                            w_next_state = ST_WRITE;
                        end else if (bus.MemReadCpu) begin
                            if (w_hit) begin
                                w_rd_hit = 1'b1;
                                w_rdata  = w_line_word;
                            end else begin
                                w_rd_miss    = 1'b1;
                                w_stall      = 1'b1;
                                w_next_state = ST_REFILL;
                            end
                        end
                    end
                end
                ST_REFILL: begin
                    w_stall    = 1'b1;
                    w_mem_req  = 1'b1;
                    w_mem_addr = {r_tag, r_index, r_beat};
                    if (bus.mem_ready) begin
                        w_fill_beat = 1'b1;
                        if (&r_beat) begin
                            w_fill_last  = 1'b1;
                            w_next_state = ST_IDLE;
                        end
                    end
                end
                ST_WRITE: begin
                    w_stall     = 1'b1;
                    w_mem_req   = 1'b1;
                    w_mem_we    = 1'b1;
                    w_mem_addr  = r_addr;
                    w_mem_wdata = r_wdata;
                    if (bus.mem_ready) begin
                        w_next_state = ST_IDLE;
                    end
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_tag        <= '0;
            r_index      <= '0;
            r_beat       <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wr_done    <= 1'b0;
            r_fill_done  <= 1'b0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_IDLE) begin
                r_wr_done   <= 1'b0;
                r_fill_done <= 1'b0;
            end
            if (w_rd_miss) begin
                r_tag        <= w_tag;
                r_index      <= w_index;
                r_beat       <= '0;
                r_miss_count <= sat_inc(r_miss_count);
            end
            // The load re-presented after its own refill was already counted as a miss.
            if (w_rd_hit && !r_fill_done) begin
                r_hit_count <= sat_inc(r_hit_count);
            end
            if (w_wr_start) begin
                r_addr  <= bus.cpu_addr;
                r_wdata <= bus.cpu_wdata;
            end
            if (w_fill_beat) begin
                r_beat <= r_beat + OFFSET_W'(1);
            end
            if (w_fill_last) begin
                r_fill_done <= 1'b1;
            end
            if (r_state == ST_WRITE && bus.mem_ready) begin
                r_wr_done <= 1'b1;
            end
        end
    end

    assign bus.cpu_rdata  = w_rdata;
    assign bus.stall      = w_stall;
    assign bus.mem_req    = w_mem_req;
    assign bus.mem_we     = w_mem_we;
    assign bus.mem_addr   = w_mem_addr;
    assign bus.mem_wdata  = w_mem_wdata;
    assign bus.hit_count  = r_hit_count;
    assign bus.miss_count = r_miss_count;

endmodule

// File: tb/tb_dm_cache_controller.sv
// tb/tb_dm_cache_controller.sv - directed self-checking bench for dm_cache_controller
module tb_dm_cache_controller;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    dm_cache_controller_if bus ();

    dm_cache_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_refill(input logic [9:0] a, input logic [31:0] d0);
        logic [9:0] exp_addr;
        @(negedge clk);
        bus.MemReadCpu = 1'b1;
        bus.MemWrite   = 1'b0;
        bus.cpu_addr   = a;
        #1;
        check("miss_stall", 32'(bus.stall), 32'd1);
        check("miss_req_comb", 32'(bus.mem_req), 32'd0);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            #1;
            exp_addr = {a[9:2], 2'(b)};
            check("rf_req", 32'(bus.mem_req), 32'd1);
            check("rf_we", 32'(bus.mem_we), 32'd0);
            check("rf_stall", 32'(bus.stall), 32'd1);
            check("rf_addr", 32'(bus.mem_addr), 32'(exp_addr));
            bus.mem_ready = 1'b1;
            bus.mem_rdata = d0 + 32'(b);
        end
        @(negedge clk);
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        #1;
        check("fill_stall", 32'(bus.stall), 32'd0);
        check("fill_rdata", bus.cpu_rdata, d0 + 32'(a[1:0]));
        check("fill_req", 32'(bus.mem_req), 32'd0);
        @(negedge clk);
        bus.MemReadCpu = 1'b0;
    endtask

    task automatic do_hit(input logic [9:0] a, input logic [31:0] exp);
        @(negedge clk);
        bus.MemReadCpu = 1'b1;
        bus.MemWrite   = 1'b0;
        bus.cpu_addr   = a;
        #1;
        check("hit_stall", 32'(bus.stall), 32'd0);
        check("hit_rdata", bus.cpu_rdata, exp);
        check("hit_req", 32'(bus.mem_req), 32'd0);
        @(negedge clk);
        bus.MemReadCpu = 1'b0;
        #1;
        check("hit_req_after", 32'(bus.mem_req), 32'd0);
    endtask

    task automatic do_store(input logic [9:0] a, input logic [31:0] d, input int lat);
        @(negedge clk);
        bus.MemWrite  = 1'b1;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        #1;
        check("st_stall", 32'(bus.stall), 32'd1);
        for (int c = 0; c < lat; c++) begin
            @(negedge clk);
            #1;
            check("st_req", 32'(bus.mem_req), 32'd1);
            check("st_we", 32'(bus.mem_we), 32'd1);
            check("st_addr", 32'(bus.mem_addr), 32'(a));
            check("st_wdata", bus.mem_wdata, d);
            check("st_wait_stall", 32'(bus.stall), 32'd1);
            if (c == lat - 1) bus.mem_ready = 1'b1;
        end
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        check("st_retire_stall", 32'(bus.stall), 32'd0);
        check("st_retire_req", 32'(bus.mem_req), 32'd0);
        @(negedge clk);
        bus.MemWrite = 1'b0;
        #1;
        check("st_after_req", 32'(bus.mem_req), 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        rst            = 1'b1;
        bus.MemReadCpu = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.cpu_addr   = '0;
        bus.cpu_wdata  = '0;
        bus.mem_rdata  = '0;
        bus.mem_ready  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall", 32'(bus.stall), 32'd0);
        check("rst_req", 32'(bus.mem_req), 32'd0);
        check("rst_we", 32'(bus.mem_we), 32'd0);
        check("rst_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_wdata", bus.mem_wdata, 32'd0);
        check("rst_rdata", bus.cpu_rdata, 32'd0);
        check("rst_hits", 32'(bus.hit_count), 32'd0);
        check("rst_misses", 32'(bus.miss_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Stray mem_ready with no request outstanding.
        @(negedge clk);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h5555_5555;
        #1;
        check("idle_rdy_req", 32'(bus.mem_req), 32'd0);
        check("idle_rdy_stall", 32'(bus.stall), 32'd0);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        check("idle_rdy_req2", 32'(bus.mem_req), 32'd0);

        do_refill(10'h024, 32'h0000_00A0);
        check("cold_misses", 32'(bus.miss_count), 32'd1);
        check("cold_hits", 32'(bus.hit_count), 32'd0);

        do_hit(10'h026, 32'h0000_00A2);
        check("hit026_hits", 32'(bus.hit_count), 32'd1);

        do_store(10'h025, 32'hDEAD_BEEF, 3);
        do_hit(10'h025, 32'hDEAD_BEEF);
        check("hit025_hits", 32'(bus.hit_count), 32'd2);
        do_hit(10'h027, 32'h0000_00A3);
        check("hit027_hits", 32'(bus.hit_count), 32'd3);

        do_store(10'h3E0, 32'h1234_5678, 1);
        check("st_miss_misses", 32'(bus.miss_count), 32'd1);
        do_refill(10'h3E0, 32'h0000_0011);
        check("no_alloc_misses", 32'(bus.miss_count), 32'd2);
        check("no_alloc_hits", 32'(bus.hit_count), 32'd3);

        // Conflict eviction from a clean state.
        pulse_reset();
        #1;
        check("rst2_misses", 32'(bus.miss_count), 32'd0);
        do_refill(10'h024, 32'h0000_00A0);
        do_refill(10'h0A4, 32'h0000_00B0);
        do_refill(10'h024, 32'h0000_00A0);
        check("conf_misses", 32'(bus.miss_count), 32'd3);
        check("conf_hits", 32'(bus.hit_count), 32'd0);
        do_hit(10'h024, 32'h0000_00A0);

        // Reset in the middle of a refill leaves the line invalid.
        @(negedge clk);
        bus.MemReadCpu = 1'b1;
        bus.cpu_addr   = 10'h150;
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            bus.mem_ready = 1'b1;
            bus.mem_rdata = 32'h0000_00E0 + 32'(b);
        end
        @(negedge clk);
        #1;
        check("abort_addr", 32'(bus.mem_addr), 32'h152);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h0000_00E2;
        #1;
        rst = 1'b1;
        #1;
        check("abort_req", 32'(bus.mem_req), 32'd0);
        check("abort_stall", 32'(bus.stall), 32'd0);
        check("abort_misses", 32'(bus.miss_count), 32'd0);
        @(negedge clk);
        rst            = 1'b0;
        bus.mem_ready  = 1'b0;
        bus.MemReadCpu = 1'b0;
        do_refill(10'h150, 32'h0000_00C0);
        check("post_abort_misses", 32'(bus.miss_count), 32'd1);
        do_hit(10'h153, 32'h0000_00C3);
        check("post_abort_hits", 32'(bus.hit_count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
